traffic_light_ctrl: RTL and testbench

- Sequences a four-phase traffic light: RED -> RED_YELLOW -> GREEN -> YELLOW -> RED.
- An internal prescaler converts i_clk cycles into phase ticks. A phase timer, reloaded by the FSM at each phase entry with a per-phase duration, counts those ticks.
- A latched pedestrian request shortens GREEN. The walk signal is driven during RED.
- Sits above the tick/timer datapath, whose only job is to count; this block owns all sequencing and timer reloads.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/traffic_light_ctrl_if.sv | 34 +++
 rtl/tick_prescaler.sv | 31 +++
 rtl/traffic_light_ctrl.sv | 120 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared phase encoding, lamp decode constants and phase order
//                for the traffic light controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        RED        = 2'd0,
        RED_YELLOW = 2'd1,
        GREEN      = 2'd2,
        YELLOW     = 2'd3
    } phase_e;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
        logic walk;
    } lamps_t;

    localparam lamps_t C_LAMPS_RED        = 4'b1001;
    localparam lamps_t C_LAMPS_RED_YELLOW = 4'b1100;
    localparam lamps_t C_LAMPS_GREEN      = 4'b0010;
    localparam lamps_t C_LAMPS_YELLOW     = 4'b0100;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            RED:        return RED_YELLOW;
            RED_YELLOW: return GREEN;
            GREEN:      return YELLOW;
            YELLOW:     return RED;
            default:    return RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl_if
//  Description : Control/status bundle between the traffic light controller
//                and its host (durations, enable, pedestrian, lamps).
//  Revision    : 1.0 - initial release
// ============================================================================
interface traffic_light_ctrl_if #(
    parameter int DW = 8
);
    logic          i_en;
    logic [DW-1:0] i_dur_red;
    logic [DW-1:0] i_dur_ry;
    logic [DW-1:0] i_dur_green;
    logic [DW-1:0] i_dur_yellow;
    logic          i_ped_req;
    logic          o_red;
    logic          o_yellow;
    logic          o_green;
    logic          o_walk;
    logic [1:0]    o_phase;
    logic          o_ped_ack;

    modport master (
        output i_en, i_dur_red, i_dur_ry, i_dur_green, i_dur_yellow, i_ped_req,
        input  o_red, o_yellow, o_green, o_walk, o_phase, o_ped_ack
    );

    modport slave (
        input  i_en, i_dur_red, i_dur_ry, i_dur_green, i_dur_yellow, i_ped_req,
        output o_red, o_yellow, o_green, o_walk, o_phase, o_ped_ack
    );
endinterface
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides the clock into single-cycle ticks every PRESCALE
//                enabled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int PRESCALE = 100
) (
    input  wire logic i_clk,
    input  wire logic i_reset,
    input  wire logic i_en,
    output logic      o_tick
);
    localparam int               c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_count;

    assign o_tick = i_en && (r_count == c_last);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tick ? '0 : r_count + c_cnt_w'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Four-phase traffic light sequencer with per-phase tick
//                timer and pedestrian-shortened GREEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int PRESCALE = 100,
    parameter int DW       = 8
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    traffic_light_ctrl_if.slave  ctrl
);
    localparam logic [DW-1:0] c_one = DW'(1);

    // A zero duration would make the timer wrap, so it is promoted to one tick.
    function automatic logic [DW-1:0] dur_floor(input logic [DW-1:0] d);
        return (d == '0) ? c_one : d;
    endfunction

    logic          w_tick;
    phase_e        r_state;
    phase_e        w_state_next;
    logic          w_advance;
    logic [DW-1:0] r_remaining;
    logic [DW-1:0] w_dur_next;
    logic          r_ped_pending;
    logic          r_ped_ack;
    logic          w_ped_set;
    logic          w_enter_red;
    lamps_t        w_lamps;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (ctrl.i_en),
        .o_tick  (w_tick)
    );

    // State register and phase timer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= RED;
            r_remaining <= dur_floor(ctrl.i_dur_red);
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_remaining <= dur_floor(w_dur_next);
            end else if (w_tick) begin
                r_remaining <= r_remaining - c_one;
            end
        end
    end

    // Next-state logic; a pending pedestrian cuts GREEN short on any tick
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        if (w_tick && ((r_remaining == c_one) ||
                       ((r_state == GREEN) && r_ped_pending))) begin
            w_advance    = 1'b1;
            w_state_next = next_phase(r_state);
        end
    end

    always_comb begin
        w_dur_next = ctrl.i_dur_red;
        case (w_state_next)
            RED:        w_dur_next = ctrl.i_dur_red;
            RED_YELLOW: w_dur_next = ctrl.i_dur_ry;
            GREEN:      w_dur_next = ctrl.i_dur_green;
            YELLOW:     w_dur_next = ctrl.i_dur_yellow;
            default:    w_dur_next = ctrl.i_dur_red;
        endcase
    end

    // Requests arriving on the RED-entry edge are served by that same entry.
    assign w_ped_set   = ctrl.i_ped_req && (r_state != RED);
    assign w_enter_red = w_advance && (w_state_next == RED);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_ped_ack <= w_enter_red && (r_ped_pending || w_ped_set);
            if (w_enter_red) begin
                r_ped_pending <= 1'b0;
            end else if (w_ped_set) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    // Moore output decode
    always_comb begin
        w_lamps = C_LAMPS_RED;
        case (r_state)
            RED:        w_lamps = C_LAMPS_RED;
            RED_YELLOW: w_lamps = C_LAMPS_RED_YELLOW;
            GREEN:      w_lamps = C_LAMPS_GREEN;
            YELLOW:     w_lamps = C_LAMPS_YELLOW;
            default:    w_lamps = C_LAMPS_RED;
        endcase
    end

    assign ctrl.o_red     = w_lamps.red;
    assign ctrl.o_yellow  = w_lamps.yellow;
    assign ctrl.o_green   = w_lamps.green;
    assign ctrl.o_walk    = w_lamps.walk;
    assign ctrl.o_phase   = r_state;
    assign ctrl.o_ped_ack = r_ped_ack;
endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_ctrl
//  Description : Directed table-driven bench for traffic_light_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;
    localparam logic [1:0] P_R  = 2'd0;
    localparam logic [1:0] P_RY = 2'd1;
    localparam logic [1:0] P_G  = 2'd2;
    localparam logic [1:0] P_Y  = 2'd3;
    // lamp order: red, yellow, green, walk
    localparam logic [3:0] L_R  = 4'b1001;
    localparam logic [3:0] L_RY = 4'b1100;
    localparam logic [3:0] L_G  = 4'b0010;
    localparam logic [3:0] L_Y  = 4'b0100;

    typedef struct {
        int         sc;
        int         cyc;
        logic [1:0] phase;
        logic [3:0] lamps;
    } vec_t;

    typedef struct {
        int len;
        int ped_cyc;
        int en_lo;
        int en_hi;
        int rst_cyc;
        int ry;
        int gchg;
        int ack_cyc;
    } scen_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t  vecs[$];
    scen_t scens[7];

    traffic_light_ctrl_if #(.DW(8)) bus ();

    traffic_light_ctrl #(
        .PRESCALE (4),
        .DW       (8)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .ctrl    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add_vec(input int sc, input int cyc,
                                    input logic [1:0] ph, input logic [3:0] lm);
        vec_t v;
        v.sc = sc; v.cyc = cyc; v.phase = ph; v.lamps = lm;
        vecs.push_back(v);
    endfunction

    function automatic logic [3:0] lamps_now();
        return {bus.o_red, bus.o_yellow, bus.o_green, bus.o_walk};
    endfunction

    // Two reset edges; returns #1 into cycle 0 with reset released.
    task automatic do_reset(input int s);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("sc%0d reset phase", s), int'(bus.o_phase), int'(P_R));
        check($sformatf("sc%0d reset lamps", s), int'(lamps_now()), int'(L_R));
        check($sformatf("sc%0d reset ack", s), int'(bus.o_ped_ack), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int ack_cnt;
        int ack_first;

        rst = 1'b1;
        bus.i_en = 1'b1; bus.i_ped_req = 1'b0;
        bus.i_dur_red = 8'd2; bus.i_dur_ry = 8'd1;
        bus.i_dur_green = 8'd3; bus.i_dur_yellow = 8'd1;

        //           len ped  enlo enhi rst  ry gchg ack
        scens[0] = '{40, -1,  -1,  -1,  -1,  1, -1,  -1};  // free run
        scens[1] = '{32, 13,  -1,  -1,  -1,  1, -1,  20};  // ped in GREEN
        scens[2] = '{32,  3,  -1,  -1,  -1,  1, -1,  -1};  // ped in RED
        scens[3] = '{16, -1,  -1,  -1,  -1,  0, -1,  -1};  // zero duration
        scens[4] = '{36, -1,   5,   9,  -1,  1, -1,  -1};  // enable freeze
        scens[5] = '{44, 13,  -1,  -1,  15,  1, -1,  -1};  // mid-phase reset
        scens[6] = '{26, -1,  -1,  -1,  -1,  1, 13,  -1};  // mid-phase dur change

        add_vec(0, 0, P_R, L_R);   add_vec(0, 7, P_R, L_R);
        add_vec(0, 8, P_RY, L_RY); add_vec(0, 11, P_RY, L_RY);
        add_vec(0, 12, P_G, L_G);  add_vec(0, 23, P_G, L_G);
        add_vec(0, 24, P_Y, L_Y);  add_vec(0, 27, P_Y, L_Y);
        add_vec(0, 28, P_R, L_R);  add_vec(0, 35, P_R, L_R);
        add_vec(0, 36, P_RY, L_RY);

        add_vec(1, 12, P_G, L_G);  add_vec(1, 15, P_G, L_G);
        add_vec(1, 16, P_Y, L_Y);  add_vec(1, 19, P_Y, L_Y);
        add_vec(1, 20, P_R, L_R);  add_vec(1, 27, P_R, L_R);
        add_vec(1, 28, P_RY, L_RY);

        add_vec(2, 8, P_RY, L_RY); add_vec(2, 12, P_G, L_G);
        add_vec(2, 23, P_G, L_G);  add_vec(2, 24, P_Y, L_Y);
        add_vec(2, 28, P_R, L_R);

        add_vec(3, 7, P_R, L_R);   add_vec(3, 8, P_RY, L_RY);
        add_vec(3, 11, P_RY, L_RY); add_vec(3, 12, P_G, L_G);

        add_vec(4, 9, P_R, L_R);   add_vec(4, 12, P_R, L_R);
        add_vec(4, 13, P_RY, L_RY); add_vec(4, 16, P_RY, L_RY);
        add_vec(4, 17, P_G, L_G);  add_vec(4, 28, P_G, L_G);
        add_vec(4, 29, P_Y, L_Y);  add_vec(4, 32, P_Y, L_Y);
        add_vec(4, 33, P_R, L_R);

        add_vec(5, 15, P_G, L_G);  add_vec(5, 16, P_R, L_R);
        add_vec(5, 23, P_R, L_R);  add_vec(5, 24, P_RY, L_RY);
        add_vec(5, 28, P_G, L_G);  add_vec(5, 32, P_G, L_G);
        add_vec(5, 39, P_G, L_G);  add_vec(5, 40, P_Y, L_Y);

        add_vec(6, 12, P_G, L_G);  add_vec(6, 16, P_G, L_G);
        add_vec(6, 23, P_G, L_G);  add_vec(6, 24, P_Y, L_Y);
        add_vec(6, 25, P_Y, L_Y);

        for (int s = 0; s < 7; s++) begin
            bus.i_en = 1'b1; bus.i_ped_req = 1'b0;
            bus.i_dur_red = 8'd2; bus.i_dur_ry = 8'(scens[s].ry);
            bus.i_dur_green = 8'd3; bus.i_dur_yellow = 8'd1;
            do_reset(s);
            ack_cnt = 0;
            ack_first = -1;
            for (int c = 0; c < scens[s].len; c++) begin
                bus.i_ped_req = (c == scens[s].ped_cyc);
                bus.i_en      = !((c >= scens[s].en_lo) && (c <= scens[s].en_hi));
                rst           = (c == scens[s].rst_cyc);
                if ((scens[s].gchg >= 0) && (c >= scens[s].gchg)) bus.i_dur_green = 8'd1;
                @(negedge clk);
                if (bus.o_ped_ack) begin
                    ack_cnt++;
                    if (ack_first < 0) ack_first = c;
                end
                foreach (vecs[k]) begin
                    if (vecs[k].sc == s && vecs[k].cyc == c) begin
                        check($sformatf("sc%0d cyc%0d phase", s, c),
                              int'(bus.o_phase), int'(vecs[k].phase));
                        check($sformatf("sc%0d cyc%0d lamps", s, c),
                              int'(lamps_now()), int'(vecs[k].lamps));
                    end
                end
                @(posedge clk); #1;
            end
            rst = 1'b0;
            bus.i_ped_req = 1'b0;
            bus.i_en = 1'b1;
            check($sformatf("sc%0d ack count", s), ack_cnt,
                  (scens[s].ack_cyc >= 0) ? 1 : 0);
            if (scens[s].ack_cyc >= 0)
                check($sformatf("sc%0d ack cycle", s), ack_first, scens[s].ack_cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
